pipe_stage_bank: RTL and testbench
==================================

# pipe_stage_bank

Parametrised pipeline register bank: carries NITEMS independent fields through NSTAGES pipeline stages with per-stage stall and flush. Successor to the fixed 32-bit ring-buffer pipeline bank. Adds per-stage valid tracking, automatic bubble insertion, optional stall back-propagation, per-field width and entry stage, and an occupancy count. Sits between the core's fetch/decode/execute/memory/writeback datapath and the hazard unit.

## Interface
- NSTAGES, default 5: number of pipeline stages; stage 0 is the earliest.
- NITEMS, default 10: number of independent fields carried.
- WIDTH, default 32: bit width of every field; narrower fields are zero-extended by the instantiator.
- START, default all 0: integer array [NITEMS]; stage at which field i is first registered, 0..NSTAGES-1.
- STALL_PROP, default 1: 1 = a stall at stage s also holds every stage below s; 0 = stalls are independent per stage.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- grst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  marks the current input as a real instruction.
- in  in  [NITEMS][WIDTH]  field values captured at each field's START stage.
- stall  in  [NSTAGES]  per-stage hold request.
- flush  in  [NSTAGES]  per-stage clear request.
- stream  out  [NITEMS][NSTAGES][WIDTH]  registered value of field i at stage s; constant 0 for s < START[i].
- valid  out  [NSTAGES]  stage s holds a real instruction.
- occ  out  $clog2(NSTAGES+1)  population count of valid (combinational from valid).

## Operation
- Effective stall: if STALL_PROP=1, est[s] = stall[s] | est[s+1], with est[NSTAGES-1] = stall[NSTAGES-1]; if STALL_PROP=0, est = stall.
- Per stage s, per edge, first matching rule wins:
  1. flush[s]: all fields at s become 0 and valid[s] becomes 0. Flush overrides stall.
  2. est[s]: all fields and valid[s] hold.
  3. s>0 and est[s-1]: bubble; fields become 0 and valid[s] becomes 0.
  4. Advance: valid[s] takes valid[s-1] (or in_valid for s=0). Field i takes stream[i][s-1] if s > START[i], takes in[i] if s = START[i], and stays 0 if s < START[i].
- A field whose START is above stage 0 is sampled from in, not from an upstream register. It is gated by the same stage-s rules.
- No registers are instantiated for s < START[i].
- Valid entering a field's START stage comes from the valid chain, not from in_valid (except s=0).

## Timing
- Reset (grst_n=0, asynchronous): every stream register and every valid bit become 0 immediately; occ=0. After deassertion, the first update occurs on the next rising edge.
- Latency: a field at START=k appears on stream[i][k] one edge after sampling. It advances one stage per non-stalled edge.
- stall/flush are sampled at the edge; they are combinational inputs and need no registering.
- Simultaneous flush[s] and stall[s+1] (STALL_PROP=1): stage s is still cleared, and stage s+1 holds.
- Simultaneous stall[s] and flush[s+1]: stage s holds; stage s+1 clears for this edge. The bubble rule would give the same contents.
- Stall on the last stage with STALL_PROP=1 freezes the entire pipe, including stage 0 input capture.
- Reset mid-stall or mid-flush: reset wins, and all state is cleared.

## Test plan
- Reset and free run: assert grst_n=0 mid-cycle, then release. Drive in_valid=1 with pc=1,2,3… at stage-0 field. Required: stream[pc][s] equals the value sampled s+1 edges earlier, valid goes 1,11,111… and occ saturates at 5.
- Decode stall with bubble, START=2 field: stall[1]=1 for one edge. Required: stages 0..1 hold, stage 2 gets value 0 and valid[2]=0 for one cycle. Then resume with no lost or duplicated pc.
- Back-propagation: STALL_PROP=1, stall[3]=1 for 2 edges. Required: stages 0..3 hold, stage 4 gets a bubble and occ drops by 1. With STALL_PROP=0, only stage 3 holds and stage 2's value is overwritten.
- Flush priority: stall[2]=1 and flush[2]=1 on the same edge. Required: stage 2 fields = 0 and valid[2]=0. Stage 3 receives a bubble if stage 2 was stalled, otherwise the old stage 2 value.
- Late-entry field: START=2 field fed 14,15,16… Required: stream[i][0..1] read 0 always. stream[i][2] shows the in value from the previous edge, and field stages 3..4 track the pc chain alignment.
- Async reset during stall: grst_n=0 while stall[4]=1. Required: all outputs 0 before the next edge, with no dependency on clk.

Source files
------------

// File: rtl/pipe_stage_bank.sv
// pipe_stage_bank: multi-field pipeline register bank with per-stage stall, flush, bubbles and occupancy
module pipe_stage_bank #(
  parameter int NSTAGES = 5,
  parameter int NITEMS = 10,
  parameter int WIDTH = 32,
  parameter logic [NITEMS-1:0][31:0] START = '0,
  parameter bit STALL_PROP = 1'b1
) (
  input  logic clk,
  input  logic grst_n,
  input  logic in_valid,
  input  logic [NITEMS-1:0][WIDTH-1:0] in,
  input  logic [NSTAGES-1:0] stall,
  input  logic [NSTAGES-1:0] flush,
  output logic [NITEMS-1:0][NSTAGES-1:0][WIDTH-1:0] stream,
  output logic [NSTAGES-1:0] valid,
  output logic [$clog2(NSTAGES+1)-1:0] occ
);
  logic [NSTAGES-1:0] est, bub, v_prev, valid_d, valid_q;
  always_comb begin
    est = '0;
    for (int s = 0; s < NSTAGES; s++) est[s] = STALL_PROP ? |(stall >> s) : stall[s];
  end
  assign bub = {est[NSTAGES-2:0], 1'b0};
  assign v_prev = {valid_q[NSTAGES-2:0], in_valid};
  assign valid_d = ~flush & ((est & valid_q) | (~est & ~bub & v_prev));
  always_ff @(posedge clk or negedge grst_n)
    if (!grst_n) valid_q <= '0;
    else valid_q <= valid_d;
  assign valid = valid_q;
  always_comb begin
    occ = '0;
    for (int s = 0; s < NSTAGES; s++) occ = occ + $bits(occ)'(valid_q[s]);
  end
  for (genvar i = 0; i < NITEMS; i++) begin : g_item
    for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
      if (s < START[i]) begin : g_none
        assign stream[i][s] = '0;
      end else begin : g_reg
        logic [WIDTH-1:0] data_src, data_d, data_q;
        if (s == START[i]) begin : g_entry
          assign data_src = in[i];
        end else begin : g_chain
          assign data_src = stream[i][s-1];
        end
        always_comb data_d = flush[s] ? '0 : est[s] ? data_q : bub[s] ? '0 : data_src;
        always_ff @(posedge clk or negedge grst_n)
          if (!grst_n) data_q <= '0;
          else data_q <= data_d;
        assign stream[i][s] = data_q;
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_bank.sv
// tb_pipe_stage_bank: directed self-checking bench for pipe_stage_bank with and without stall propagation
module tb_pipe_stage_bank;
  localparam int NS = 5;
  localparam int NI = 2;
  localparam int W = 32;
  localparam logic [NI-1:0][31:0] ST = {32'd2, 32'd0};
  logic clk = 1'b0;
  logic grst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [NI-1:0][W-1:0] din = '0;
  logic [NS-1:0] stall = '0;
  logic [NS-1:0] flush = '0;
  logic [NI-1:0][NS-1:0][W-1:0] sp, sn;
  logic [NS-1:0] vp, vn;
  logic [2:0] op, on;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  pipe_stage_bank #(.NSTAGES(NS), .NITEMS(NI), .WIDTH(W), .START(ST), .STALL_PROP(1'b1)) u_p (
    .clk(clk), .grst_n(grst_n), .in_valid(in_valid), .in(din), .stall(stall), .flush(flush),
    .stream(sp), .valid(vp), .occ(op));
  pipe_stage_bank #(.NSTAGES(NS), .NITEMS(NI), .WIDTH(W), .START(ST), .STALL_PROP(1'b0)) u_n (
    .clk(clk), .grst_n(grst_n), .in_valid(in_valid), .in(din), .stall(stall), .flush(flush),
    .stream(sn), .valid(vn), .occ(on));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int k);
    din[0] = W'(k);
    din[1] = W'(k + 13);
    in_valid = 1'b1;
  endtask
  task automatic fill();
    stall = '0;
    flush = '0;
    @(negedge clk);
    grst_n = 1'b0;
    #1 grst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      drive(k);
      tick();
    end
  endtask
  task automatic test_reset();
    #3;
    n_chk++;
    if ({sp, sn, vp, vn, op, on} !== '0) begin n_fail++; $display("FAIL reset_initial got %h exp 0", {sp, sn, vp, vn, op, on}); end
    @(negedge clk);
    grst_n = 1'b1;
    drive(1);
    tick();
    tick();
    @(negedge clk);
    #1 grst_n = 1'b0;
    #1;
    n_chk++;
    if ({sp, sn, vp, vn, op, on} !== '0) begin n_fail++; $display("FAIL reset_midcycle got %h exp 0", {sp, sn, vp, vn, op, on}); end
  endtask
  task automatic test_free_run();
    logic [W-1:0] e0, e1;
    fill();
    @(negedge clk);
    grst_n = 1'b0;
    #1 grst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      drive(k);
      tick();
      for (int s = 0; s < NS; s++) begin
        e0 = (k > s) ? W'(k - s) : '0;
        e1 = (s >= 2 && k >= s - 1) ? W'(k + 15 - s) : '0;
        n_chk++;
        if (sp[0][s] !== e0) begin n_fail++; $display("FAIL run_pc k=%0d s=%0d got %0d exp %0d", k, s, sp[0][s], e0); end
        n_chk++;
        if (sp[1][s] !== e1) begin n_fail++; $display("FAIL run_late k=%0d s=%0d got %0d exp %0d", k, s, sp[1][s], e1); end
        n_chk++;
        if (vp[s] !== (k > s)) begin n_fail++; $display("FAIL run_valid k=%0d s=%0d got %b exp %b", k, s, vp[s], k > s); end
      end
      n_chk++;
      if (op !== 3'((k > 5) ? 5 : k)) begin n_fail++; $display("FAIL run_occ k=%0d got %0d exp %0d", k, op, (k > 5) ? 5 : k); end
      n_chk++;
      if (sn !== sp) begin n_fail++; $display("FAIL run_noprop k=%0d got %h exp %h", k, sn, sp); end
    end
  endtask
  task automatic test_decode_stall();
    fill();
    drive(8);
    stall = 5'b00010;
    tick();
    n_chk++;
    if (sp[0] !== {32'd4, 32'd5, 32'd0, 32'd6, 32'd7}) begin n_fail++; $display("FAIL dstall_p got %h", sp[0]); end
    n_chk++;
    if (vp !== 5'b11011 || op !== 3'd4) begin n_fail++; $display("FAIL dstall_pv got %b/%0d exp 11011/4", vp, op); end
    n_chk++;
    if (sp[1][2] !== 32'd0) begin n_fail++; $display("FAIL dstall_late got %0d exp 0", sp[1][2]); end
    n_chk++;
    if (sn[0] !== {32'd4, 32'd5, 32'd0, 32'd6, 32'd8} || vn !== 5'b11011) begin n_fail++; $display("FAIL dstall_n got %h/%b", sn[0], vn); end
    stall = '0;
    tick();
    n_chk++;
    if (sp[0] !== {32'd5, 32'd0, 32'd6, 32'd7, 32'd8} || vp !== 5'b10111) begin n_fail++; $display("FAIL dresume1 got %h/%b", sp[0], vp); end
    n_chk++;
    if (sp[1][2] !== 32'd21) begin n_fail++; $display("FAIL dresume_late got %0d exp 21", sp[1][2]); end
    drive(9);
    tick();
    drive(10);
    tick();
    n_chk++;
    if (sp[0] !== {32'd6, 32'd7, 32'd8, 32'd9, 32'd10} || vp !== 5'b11111) begin n_fail++; $display("FAIL dresume3 got %h/%b", sp[0], vp); end
  endtask
  task automatic test_back_prop();
    fill();
    drive(8);
    stall = 5'b01000;
    tick();
    n_chk++;
    if (sp[0] !== {32'd0, 32'd4, 32'd5, 32'd6, 32'd7} || vp !== 5'b01111 || op !== 3'd4) begin n_fail++; $display("FAIL bprop_p1 got %h/%b/%0d", sp[0], vp, op); end
    n_chk++;
    if (sn[0] !== {32'd0, 32'd4, 32'd6, 32'd7, 32'd8} || vn !== 5'b01111) begin n_fail++; $display("FAIL bprop_n1 got %h/%b", sn[0], vn); end
    tick();
    n_chk++;
    if (sp[0] !== {32'd0, 32'd4, 32'd5, 32'd6, 32'd7} || op !== 3'd4) begin n_fail++; $display("FAIL bprop_p2 got %h/%0d", sp[0], op); end
    n_chk++;
    if (sn[0] !== {32'd0, 32'd4, 32'd7, 32'd8, 32'd8} || on !== 3'd4) begin n_fail++; $display("FAIL bprop_n2 got %h/%0d", sn[0], on); end
    stall = '0;
  endtask
  task automatic test_flush_priority();
    fill();
    drive(8);
    stall = 5'b00100;
    flush = 5'b00100;
    tick();
    n_chk++;
    if (sp[0] !== {32'd4, 32'd0, 32'd0, 32'd6, 32'd7} || vp !== 5'b10011 || op !== 3'd3) begin n_fail++; $display("FAIL fprio_p got %h/%b/%0d", sp[0], vp, op); end
    n_chk++;
    if (sp[1] !== {32'd19, 32'd0, 32'd0, 32'd0, 32'd0}) begin n_fail++; $display("FAIL fprio_late got %h", sp[1]); end
    n_chk++;
    if (sn[0] !== {32'd4, 32'd0, 32'd0, 32'd7, 32'd8} || vn !== 5'b10011) begin n_fail++; $display("FAIL fprio_n got %h/%b", sn[0], vn); end
    fill();
    drive(8);
    flush = 5'b00100;
    tick();
    n_chk++;
    if (sp[0] !== {32'd4, 32'd5, 32'd0, 32'd7, 32'd8} || vp !== 5'b11011 || sn[0] !== sp[0]) begin n_fail++; $display("FAIL fonly got %h/%b/%h", sp[0], vp, sn[0]); end
    fill();
    drive(8);
    stall = 5'b00100;
    flush = 5'b00010;
    tick();
    n_chk++;
    if (sp[0] !== {32'd4, 32'd0, 32'd5, 32'd0, 32'd7} || vp !== 5'b10101 || op !== 3'd3) begin n_fail++; $display("FAIL fmix_p got %h/%b/%0d", sp[0], vp, op); end
    n_chk++;
    if (sn[0] !== {32'd4, 32'd0, 32'd5, 32'd0, 32'd8} || vn !== 5'b10101) begin n_fail++; $display("FAIL fmix_n got %h/%b", sn[0], vn); end
    stall = '0;
    flush = '0;
  endtask
  task automatic test_late_entry();
    fill();
    drive(8);
    tick();
    n_chk++;
    if (sp[1] !== {32'd19, 32'd20, 32'd21, 32'd0, 32'd0} || sn[1] !== sp[1]) begin n_fail++; $display("FAIL late_a got %h/%h", sp[1], sn[1]); end
    drive(9);
    tick();
    n_chk++;
    if (sp[1] !== {32'd20, 32'd21, 32'd22, 32'd0, 32'd0}) begin n_fail++; $display("FAIL late_b got %h", sp[1]); end
  endtask
  task automatic test_async_reset_stall();
    fill();
    drive(8);
    stall = 5'b10000;
    tick();
    n_chk++;
    if (sp[0] !== {32'd3, 32'd4, 32'd5, 32'd6, 32'd7} || vp !== 5'b11111 || sp[1] !== {32'd18, 32'd19, 32'd20, 32'd0, 32'd0}) begin n_fail++; $display("FAIL freeze_p got %h/%b/%h", sp[0], vp, sp[1]); end
    n_chk++;
    if (sn[0] !== {32'd3, 32'd5, 32'd6, 32'd7, 32'd8}) begin n_fail++; $display("FAIL freeze_n got %h", sn[0]); end
    #2 grst_n = 1'b0;
    #1;
    n_chk++;
    if ({sp, sn, vp, vn, op, on} !== '0) begin n_fail++; $display("FAIL async_rst got %h exp 0", {sp, sn, vp, vn, op, on}); end
    stall = '0;
    @(negedge clk);
    grst_n = 1'b1;
  endtask
  initial begin
    test_reset();
    test_free_run();
    test_decode_stall();
    test_back_prop();
    test_flush_priority();
    test_late_entry();
    test_async_reset_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
